// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and data access, with per-port stalls.
// Optional ARB_TIMEOUT_EN adds a grant watchdog that aborts unanswered accesses and sets a sticky err_o.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [31:0]   if_rdata_o,
    output logic          if_stall_o,
    input  logic          dm_read_i,
    input  logic          dm_write_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [31:0]   dm_wdata_i,
    output logic [31:0]   dm_rdata_o,
    output logic          dm_stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    input  logic          mem_ack_i,
    output logic          err_o
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        GNT_IF,
        GNT_DM,
        RSP_IF,
        RSP_DM
    } state_t;

    state_t          state_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [31:0]     mem_wdata_q;
    logic [31:0]     if_rdata_q;
    logic [31:0]     dm_rdata_q;
    logic [SW-1:0]   starve_q;

    logic dm_pend;
    logic if_starved;
    logic grant_dm_d;

    assign dm_pend    = dm_read_i | dm_write_i;
    assign if_starved = if_req_i && (starve_q == SW'(STARVE_LIMIT));
    assign grant_dm_d = dm_pend && !if_starved;

`ifdef ARB_TIMEOUT_EN
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WDW-1:0] wd_q;
    logic           err_q;
    logic           wd_expired;
    assign wd_expired = (wd_q == WDW'(TIMEOUT - 1));
    assign err_o      = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign err_o          = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            starve_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    wd_q <= '0;
`endif
                    // Data side wins unless fetch has already been passed over STARVE_LIMIT times.
                    if (grant_dm_d) begin
                        state_q     <= GNT_DM;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_write_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                        if (if_req_i && (starve_q != SW'(STARVE_LIMIT)))
                            starve_q <= starve_q + 1'b1;
                    end else if (if_req_i) begin
                        state_q     <= GNT_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                        starve_q    <= '0;
                    end
                end
                GNT_IF: begin
                    if (mem_ack_i) begin
                        mem_req_q  <= 1'b0;
                        if_rdata_q <= mem_rdata_i;
                        state_q    <= RSP_IF;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wd_expired) begin
                        mem_req_q  <= 1'b0;
                        if_rdata_q <= '0;
                        err_q      <= 1'b1;
                        state_q    <= RSP_IF;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                GNT_DM: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q)
                            dm_rdata_q <= mem_rdata_i;
                        state_q   <= RSP_DM;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wd_expired) begin
                        mem_req_q  <= 1'b0;
                        dm_rdata_q <= '0;
                        err_q      <= 1'b1;
                        state_q    <= RSP_DM;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                RSP_IF, RSP_DM: state_q <= IDLE;
                default:        state_q <= IDLE;
            endcase
        end
    end

    // Each stall is released only during that port's single response cycle.
    assign if_stall_o  = if_req_i & (state_q != RSP_IF);
    assign dm_stall_o  = dm_pend & (state_q != RSP_DM);

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: grant scoreboard, memory responder and per-scenario tasks.
// Define ARB_TIMEOUT_EN for both RTL and bench to exercise the watchdog scenarios.
module tb_mem_port_arbiter;
    localparam int AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic [31:0]   if_rdata_o;
    logic          if_stall_o;
    logic          dm_read_i;
    logic          dm_write_i;
    logic [AW-1:0] dm_addr_i;
    logic [31:0]   dm_wdata_i;
    logic [31:0]   dm_rdata_o;
    logic          dm_stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_ack_i;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.AW(AW), .STARVE_LIMIT(2), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
        .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .err_o(err_o)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [31:0]   wdata;
    } grant_t;

    grant_t exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] mem_model [logic [AW-1:0]];
    int ack_wait = 0;
    bit ack_en = 1'b1;

    function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return ~a[31:0];
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_grant(input logic [AW-1:0] a, input logic we, input logic [31:0] wd);
        grant_t g;
        g.addr = a; g.we = we; g.wdata = wd;
        exp_q.push_back(g);
    endtask

    // Memory responder: acks after ack_wait extra cycles of mem_req_o.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (mem_req_o && ack_en) begin
                if (wait_cnt == ack_wait) begin
                    mem_ack_i = 1'b1;
                    if (mem_we_o) begin
                        mem_model[mem_addr_o] = mem_wdata_o;
                        mem_rdata_i = 32'h0;
                    end else begin
                        mem_rdata_i = model_rd(mem_addr_o);
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Grant monitor: every new memory request is popped against the scoreboard.
    initial begin
        logic prev_req;
        grant_t g;
        prev_req = 1'b0;
        forever begin
            @(negedge clk_i);
            if (mem_req_o === 1'b1 && prev_req !== 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected got addr=%h we=%b want no grant", mem_addr_o, mem_we_o);
                end else begin
                    g = exp_q.pop_front();
                    $display("grant addr=%h we=%b wdata=%h", mem_addr_o, mem_we_o, mem_wdata_o);
                    if ({mem_addr_o, mem_we_o, mem_wdata_o} !== {g.addr, g.we, g.wdata}) begin
                        errors++;
                        $display("FAIL grant_order got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                                 mem_addr_o, mem_we_o, mem_wdata_o, g.addr, g.we, g.wdata);
                    end
                end
            end
            prev_req = mem_req_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, want finish");
        $fatal(1);
    end

    task automatic test_reset();
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, err_o, if_stall_o, dm_stall_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {mem_req_o, mem_we_o, err_o, if_stall_o, dm_stall_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wd=%h ird=%h drd=%h want 0", mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o);
        end
        if_req_i = 1'b1;
        #1;
        checks++;
        if (if_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_if_stall got %b want 1", if_stall_o);
        end
        if_req_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_if_only();
        if_req_i = 1'b1; if_addr_i = 32'h10;
        push_grant(32'h10, 1'b0, dm_wdata_i);
        tick();
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 32'h10}) begin
            errors++;
            $display("FAIL if_only_c1 got req=%b we=%b addr=%h want 1 0 00000010", mem_req_o, mem_we_o, mem_addr_o);
        end
        tick();
        checks++;
        if ({if_rdata_o, if_stall_o} !== {32'h2008000A, 1'b0}) begin
            errors++;
            $display("FAIL if_only_c2 got rdata=%h stall=%b want 2008000a 0", if_rdata_o, if_stall_o);
        end
        tick();
        checks++;
        if (if_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL if_only_c3_stall got %b want 1", if_stall_o);
        end
        if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        if_req_i = 1'b1; if_addr_i = 32'h20;
        dm_write_i = 1'b1; dm_addr_i = 32'h40; dm_wdata_i = 32'hDEADBEEF;
        push_grant(32'h40, 1'b1, 32'hDEADBEEF);
        push_grant(32'h20, 1'b0, 32'hDEADBEEF);
        tick();
        checks++;
        if ({mem_req_o, mem_we_o, mem_wdata_o} !== {2'b11, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL simul_dm_grant got req=%b we=%b wdata=%h want 1 1 deadbeef", mem_req_o, mem_we_o, mem_wdata_o);
        end
        tick();
        checks++;
        if ({dm_stall_o, if_stall_o} !== 2'b01) begin
            errors++;
            $display("FAIL simul_c2_stalls got dm=%b if=%b want 0 1", dm_stall_o, if_stall_o);
        end
        dm_write_i = 1'b0;
        tick();
        // Cycle 3 is the IDLE cycle that grants IF; its request is visible in cycle 4.
        tick();
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h20}) begin
            errors++;
            $display("FAIL simul_if_grant got req=%b we=%b addr=%h want 1 0 00000020", mem_req_o, mem_we_o, mem_addr_o);
        end
        tick();
        checks++;
        if ({if_rdata_o, if_stall_o} !== {32'hFFFFFFDF, 1'b0}) begin
            errors++;
            $display("FAIL simul_if_data got rdata=%h stall=%b want ffffffdf 0", if_rdata_o, if_stall_o);
        end
        if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        if_req_i = 1'b1; if_addr_i = 32'h30;
        dm_read_i = 1'b1; dm_addr_i = 32'h80; dm_wdata_i = 32'h0;
        for (int k = 0; k < 2; k++) begin
            push_grant(32'h80, 1'b0, 32'h0);
            push_grant(32'h80, 1'b0, 32'h0);
            push_grant(32'h30, 1'b0, 32'h0);
        end
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 2) begin
                checks++;
                if ({dm_rdata_o, dm_stall_o, if_stall_o} !== {32'hFFFFFF7F, 2'b01}) begin
                    errors++;
                    $display("FAIL starve_dm_rsp got rdata=%h dm=%b if=%b want ffffff7f 0 1", dm_rdata_o, dm_stall_o, if_stall_o);
                end
            end
            if (i == 8) begin
                checks++;
                if ({if_rdata_o, if_stall_o, dm_stall_o} !== {32'hFFFFFFCF, 2'b01}) begin
                    errors++;
                    $display("FAIL starve_if_rsp got rdata=%h if=%b dm=%b want ffffffcf 0 1", if_rdata_o, if_stall_o, dm_stall_o);
                end
            end
        end
        checks++;
        if (if_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL starve_last_if got stall=%b want 0", if_stall_o);
        end
        if_req_i = 1'b0; dm_read_i = 1'b0;
        tick();
    endtask

    task automatic test_wait_states();
        ack_wait = 3;
        dm_read_i = 1'b1; dm_addr_i = 32'h44; dm_wdata_i = 32'h12345678;
        push_grant(32'h44, 1'b0, 32'h12345678);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if ({mem_req_o, mem_addr_o, mem_wdata_o, dm_stall_o} !== {1'b1, 32'h44, 32'h12345678, 1'b1}) begin
                errors++;
                $display("FAIL wait_hold_c%0d got req=%b addr=%h wd=%h stall=%b want 1 00000044 12345678 1",
                         i, mem_req_o, mem_addr_o, mem_wdata_o, dm_stall_o);
            end
        end
        tick();
        checks++;
        if ({dm_rdata_o, dm_stall_o, mem_req_o} !== {32'hCAFEF00D, 2'b00}) begin
            errors++;
            $display("FAIL wait_rsp_c5 got rdata=%h stall=%b req=%b want cafef00d 0 0", dm_rdata_o, dm_stall_o, mem_req_o);
        end
        dm_read_i = 1'b0;
        ack_wait = 0;
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        ack_wait = 15;
        dm_read_i = 1'b1; dm_addr_i = 32'h50;
        push_grant(32'h50, 1'b0, dm_wdata_i);
        for (int i = 1; i <= 17; i++) tick();
        checks++;
        if ({dm_rdata_o, err_o, dm_stall_o} !== {32'hFFFFFFAF, 2'b00}) begin
            errors++;
            $display("FAIL ack_wins_timeout got rdata=%h err=%b stall=%b want ffffffaf 0 0", dm_rdata_o, err_o, dm_stall_o);
        end
        dm_read_i = 1'b0;
        ack_wait = 0;
        tick();
        ack_en = 1'b0;
        dm_read_i = 1'b1; dm_addr_i = 32'h4C;
        push_grant(32'h4C, 1'b0, dm_wdata_i);
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++;
            if (mem_req_o !== 1'b1) begin
                errors++;
                $display("FAIL timeout_hold_c%0d got req=%b want 1", i, mem_req_o);
            end
        end
        tick();
        checks++;
        if ({mem_req_o, dm_rdata_o, err_o, dm_stall_o} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_abort got req=%b rdata=%h err=%b stall=%b want 0 00000000 1 0",
                     mem_req_o, dm_rdata_o, err_o, dm_stall_o);
        end
        dm_read_i = 1'b0;
        ack_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got err=%b want 1", err_o);
        end
    endtask
`else
    task automatic test_timeout();
        int n;
        ack_en = 1'b0;
        dm_read_i = 1'b1; dm_addr_i = 32'h50;
        push_grant(32'h50, 1'b0, dm_wdata_i);
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if ({mem_req_o, err_o, dm_stall_o} !== 3'b101) begin
                errors++;
                $display("FAIL no_timeout_c%0d got req=%b err=%b stall=%b want 1 0 1", i, mem_req_o, err_o, dm_stall_o);
            end
        end
        ack_en = 1'b1;
        n = 0;
        while (dm_stall_o !== 1'b0 && n < 5) begin
            tick();
            n++;
        end
        checks++;
        if ({dm_rdata_o, dm_stall_o, err_o} !== {32'hFFFFFFAF, 2'b00}) begin
            errors++;
            $display("FAIL no_timeout_rsp got rdata=%h stall=%b err=%b want ffffffaf 0 0", dm_rdata_o, dm_stall_o, err_o);
        end
        dm_read_i = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid_access();
        ack_en = 1'b0;
        dm_read_i = 1'b1; dm_addr_i = 32'h48;
        push_grant(32'h48, 1'b0, dm_wdata_i);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, err_o, dm_rdata_o, if_rdata_o} !== '0) begin
            errors++;
            $display("FAIL rst_async got req=%b err=%b drd=%h ird=%h want 0 0 0 0", mem_req_o, err_o, dm_rdata_o, if_rdata_o);
        end
        dm_read_i = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hBAD0BAD0;
        tick();
        checks++;
        if ({mem_req_o, dm_rdata_o, if_rdata_o} !== '0) begin
            errors++;
            $display("FAIL rst_stray_ack got req=%b drd=%h ird=%h want 0 0 0", mem_req_o, dm_rdata_o, if_rdata_o);
        end
        ack_en = 1'b1;
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h10;
        push_grant(32'h10, 1'b0, dm_wdata_i);
        tick();
        tick();
        checks++;
        if ({if_rdata_o, if_stall_o} !== {32'h2008000A, 1'b0}) begin
            errors++;
            $display("FAIL rst_next_if got rdata=%h stall=%b want 2008000a 0", if_rdata_o, if_stall_o);
        end
        if_req_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_read_i = 1'b0; dm_write_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_model[32'h10] = 32'h2008000A;
        mem_model[32'h44] = 32'hCAFEF00D;

        test_reset();
        test_if_only();
        test_simultaneous();
        test_starvation();
        test_wait_states();
        test_timeout();
        test_reset_mid_access();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL grants_outstanding got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) port and its data-memory (MEM stage) port.
- Sequences each access with a req/ack handshake to the memory.
- Generates per-port stall signals that freeze the pipeline registers until data is available.
- Sits between the pipelined CPU top and the memory model. It replaces the separate instruction and data memories when a unified memory is used.

Parameters:
- AW, 32, address width of all address ports.
- STARVE_LIMIT, 2, number of consecutive IF denials allowed before IF is forced to win.
- TIMEOUT, 16, cycles to wait for mem_ack_i before aborting. Used only with ARB_TIMEOUT_EN.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- if_req_i  input  1  IF wants an instruction fetch.
- if_addr_i  input  AW  fetch address (PC).
- if_rdata_o  output  32  fetched instruction.
- if_stall_o  output  1  freezes PC and the IF/ID register.
- dm_read_i  input  1  MEM stage load.
- dm_write_i  input  1  MEM stage store.
- dm_addr_i  input  AW  data address (ALU result).
- dm_wdata_i  input  32  store data.
- dm_rdata_o  output  32  load data.
- dm_stall_o  output  1  freezes the pipeline at and upstream of MEM.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  1 = write.
- mem_addr_o  output  AW  memory address.
- mem_wdata_o  output  32  memory write data.
- mem_rdata_i  input  32  memory read data; valid when mem_ack_i = 1.
- mem_ack_i  input  1  single-cycle completion strobe.
- err_o  output  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n = 0):
  - State IDLE; mem_req_o, mem_we_o, err_o = 0.
  - mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o = 0.
  - Starvation counter = 0.
  - A reset arriving mid-transaction abandons that transaction. An ack arriving after reset release is ignored.
- FSM states: IDLE, GNT_IF, GNT_DM, RSP_IF, RSP_DM.
- IDLE arbitration:
  - dm_pend = dm_read_i | dm_write_i.
  - If dm_pend and not (if_req_i and starve_cnt == STARVE_LIMIT): go to GNT_DM.
  - Else if if_req_i: go to GNT_IF.
  - Else: stay in IDLE.
- On entering a GNT state, register the access:
  - mem_req_o = 1.
  - mem_addr_o = the winning port's address.
  - mem_we_o = dm_write_i for DM, 0 for IF.
  - mem_wdata_o = dm_wdata_i.
  - These outputs hold constant until ack.
- If dm_read_i and dm_write_i are both 1, the access is a write.
- Starvation counter:
  - +1 at every IDLE decision where if_req_i = 1 but DM wins; saturates at STARVE_LIMIT.
  - Cleared when IF is granted.
- GNT_x:
  - Hold until mem_ack_i = 1.
  - On the ack edge: mem_req_o goes to 0; mem_rdata_i is captured into if_rdata_o or dm_rdata_o (DM reads only; writes leave dm_rdata_o unchanged); go to RSP_x.
- RSP_x: one cycle, then IDLE. This is the only cycle in which that port's stall is released.
- Stall outputs:
  - if_stall_o = if_req_i & (state != RSP_IF).
  - dm_stall_o = dm_pend & (state != RSP_DM).
  - Both are combinational from state and inputs.
- Latency with a zero-wait memory (ack in the first GNT cycle):
  - Request seen in cycle 0, mem_req_o high in cycle 1, data and stall low in cycle 2.
  - Minimum 3 cycles per access; each wait state adds 1.
- A request dropped while in GNT (e.g. a flush) still completes on the memory. Its result is captured, but no stall depends on it.
- mem_ack_i is ignored outside the GNT states.
- Address and data pass through unmodified; the block performs no alignment checks.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A watchdog counts cycles spent in a GNT state.
  - When it reaches TIMEOUT without an ack: mem_req_o goes to 0, the port's rdata becomes 32'h0, err_o is set to 1 (sticky until reset), and the FSM goes to RSP_x.
  - An ack on the same edge as the timeout wins; err_o is not set.
- Without the macro: no watchdog; GNT waits indefinitely; err_o is tied to 0.

Test Plan:
- IF only, zero-wait memory: if_req_i = 1, if_addr_i = 0x10, memory returns 0x2008000A.
  - Required: mem_req_o = 1 and mem_addr_o = 0x10 with mem_we_o = 0 in cycle 1.
  - Required: if_rdata_o = 0x2008000A and if_stall_o = 0 in cycle 2 only.
- Simultaneous requests: if_req_i with dm_write_i, dm_addr_i = 0x40, dm_wdata_i = 0xDEADBEEF.
  - Required: DM is granted first with mem_we_o = 1 and mem_wdata_o = 0xDEADBEEF; dm_stall_o drops in cycle 2.
  - Required: IF is granted in cycle 3.
- Starvation: STARVE_LIMIT = 2, dm_read_i held high, if_req_i held high.
  - Required: grant order DM, DM, IF, DM, DM, IF.
- Wait states: ack delayed 3 cycles.
  - Required: mem_req_o, mem_addr_o and mem_wdata_o are stable for 4 cycles.
  - Required: dm_stall_o stays 1 until the RSP cycle, with total latency 6 cycles.
- Reset mid-access: rst_n = 0 during GNT_DM.
  - Required: mem_req_o = 0 immediately, without waiting for a clock edge.
  - Required: after release, a stray ack has no effect and the next IF request is served normally.
- Timeout, ARB_TIMEOUT_EN defined, TIMEOUT = 16, no ack.
  - Required: mem_req_o drops after 16 GNT cycles; dm_rdata_o = 0; err_o = 1 and stays 1; dm_stall_o = 0 on the following cycle.
